br_mask_ctrl: RTL and testbench

//  Branch-stack controller. Allocates checkpoint slots to dispatched branches, holds the live-branch mask and per-slot dependency masks.

---
 rtl/br_mask_if.sv | 30 +++
 rtl/br_mask_ctrl.sv | 60 ++++++
 tb/tb_br_mask_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/br_mask_if.sv
// br_mask_if: dispatch/resolve/recovery bundle for the branch-stack controller.
interface br_mask_if #(
    parameter int BR_NUM   = 4,
    parameter int BR_CNT_W = $clog2(BR_NUM + 1)
);
    logic                br_disp_i;
    logic                br_rslv_vld_i;
    logic [BR_NUM-1:0]   br_rslv_idx_i;
    logic                br_rslv_cor_i;
    logic [BR_NUM-1:0]   br_mask_o;
    logic                br_gnt_o;
    logic [BR_NUM-1:0]   br_alloc_idx_o;
    logic [BR_NUM-1:0]   br_alloc_dep_o;
    logic                br_full_o;
    logic                br_stall_o;
    logic [BR_CNT_W-1:0] br_cnt_o;
    logic                rc_vld_o;
    logic [BR_NUM-1:0]   rc_sel_o;
    logic [BR_NUM-1:0]   rc_squash_o;
    modport master (
        output br_disp_i, br_rslv_vld_i, br_rslv_idx_i, br_rslv_cor_i,
        input  br_mask_o, br_gnt_o, br_alloc_idx_o, br_alloc_dep_o, br_full_o,
               br_stall_o, br_cnt_o, rc_vld_o, rc_sel_o, rc_squash_o
    );
    modport slave (
        input  br_disp_i, br_rslv_vld_i, br_rslv_idx_i, br_rslv_cor_i,
        output br_mask_o, br_gnt_o, br_alloc_idx_o, br_alloc_dep_o, br_full_o,
               br_stall_o, br_cnt_o, rc_vld_o, rc_sel_o, rc_squash_o
    );
endinterface

// File: rtl/br_mask_ctrl.sv
// br_mask_ctrl: branch-stack slot allocator with live mask, dependency masks and mispredict recovery.
module br_mask_ctrl #(
    parameter int BR_NUM   = 4,
    parameter int BR_CNT_W = $clog2(BR_NUM + 1)
) (
    input logic clk,
    input logic rst,
    br_mask_if.slave b
);
    typedef enum logic {NORMAL, RECOVER} state_t;
    localparam logic [BR_NUM-1:0] ONE = BR_NUM'(1);
    state_t state, state_nxt;
    logic [BR_NUM-1:0] mask, mask_nxt, dep_k, cor_clr, free_low, alloc_dep;
    logic [BR_NUM-1:0] dep [BR_NUM];
    logic [BR_CNT_W-1:0] cnt, cnt_nxt;
    logic one_hot, acc, mis_acc, gnt, full;
    always_comb begin
        dep_k     = '0;
        cnt_nxt   = '0;
        one_hot   = (b.br_rslv_idx_i != '0) && ((b.br_rslv_idx_i & (b.br_rslv_idx_i - ONE)) == '0);
        acc       = b.br_rslv_vld_i && one_hot && ((b.br_rslv_idx_i & mask) != '0);
        mis_acc   = acc && !b.br_rslv_cor_i;
        cor_clr   = (acc && b.br_rslv_cor_i) ? b.br_rslv_idx_i : '0;
        full      = &mask;
        free_low  = ~mask & (mask + ONE);
        gnt       = b.br_disp_i && !full && !mis_acc && state == NORMAL;
        alloc_dep = mask & ~cor_clr;
        for (int i = 0; i < BR_NUM; i++)
            dep_k = dep_k | (b.br_rslv_idx_i[i] ? dep[i] : '0);
        // the checkpoint's dep mask is exactly the set of branches older than k
        mask_nxt  = mis_acc ? dep_k : alloc_dep | (gnt ? free_low : '0);
        for (int i = 0; i < BR_NUM; i++)
            cnt_nxt = cnt_nxt + BR_CNT_W'(mask_nxt[i]);
        state_nxt = mis_acc ? RECOVER : NORMAL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            mask  <= '0;
            cnt   <= '0;
            for (int i = 0; i < BR_NUM; i++) dep[i] <= '0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            cnt   <= cnt_nxt;
            for (int i = 0; i < BR_NUM; i++)
                dep[i] <= (gnt && free_low[i]) ? alloc_dep : dep[i] & ~cor_clr;
        end
    end
    assign b.br_mask_o      = mask;
    assign b.br_gnt_o       = gnt;
    assign b.br_alloc_idx_o = gnt ? free_low : '0;
    assign b.br_alloc_dep_o = alloc_dep;
    assign b.br_full_o      = full;
    assign b.br_stall_o     = full || mis_acc || state == RECOVER;
    assign b.br_cnt_o       = cnt;
    assign b.rc_vld_o       = mis_acc;
    assign b.rc_sel_o       = mis_acc ? b.br_rslv_idx_i : '0;
    assign b.rc_squash_o    = mis_acc ? mask & ~dep_k : '0;
endmodule

// File: tb/tb_br_mask_ctrl.sv
// tb_br_mask_ctrl: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_br_mask_ctrl;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    br_mask_if #(.BR_NUM(4)) bus();
    br_mask_ctrl #(.BR_NUM(4)) dut (.clk(clk), .rst(rst), .b(bus));
    typedef struct {
        int id;
        logic [3:0] m, ai, ad, sel, sq;
        logic gnt, st, rv;
    } exp_t;
    exp_t q[$];
    int asserts = 0;
    int errors = 0;
    int vec = 0;
    task automatic chk(input string n, input int id, input logic [7:0] a, input logic [7:0] e);
        asserts++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", n, id, a, e);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] pc;
            e = q.pop_front();
            pc = 8'(e.m[0]) + 8'(e.m[1]) + 8'(e.m[2]) + 8'(e.m[3]);
            chk("mask", e.id, 8'(bus.br_mask_o), 8'(e.m));
            chk("gnt", e.id, 8'(bus.br_gnt_o), 8'(e.gnt));
            chk("alloc_idx", e.id, 8'(bus.br_alloc_idx_o), 8'(e.ai));
            chk("alloc_dep", e.id, 8'(bus.br_alloc_dep_o), 8'(e.ad));
            chk("full", e.id, 8'(bus.br_full_o), 8'(&e.m));
            chk("stall", e.id, 8'(bus.br_stall_o), 8'(e.st));
            chk("cnt", e.id, 8'(bus.br_cnt_o), pc);
            chk("rc_vld", e.id, 8'(bus.rc_vld_o), 8'(e.rv));
            chk("rc_sel", e.id, 8'(bus.rc_sel_o), 8'(e.sel));
            chk("rc_squash", e.id, 8'(bus.rc_squash_o), 8'(e.sq));
        end
    end
    task automatic drive(input logic d, input logic v, input logic [3:0] idx, input logic c);
        bus.br_disp_i = d;
        bus.br_rslv_vld_i = v;
        bus.br_rslv_idx_i = idx;
        bus.br_rslv_cor_i = c;
    endtask
    task automatic cyc(input logic d, input logic v, input logic [3:0] idx, input logic c,
                       input logic [3:0] m, input logic g, input logic [3:0] ai, input logic [3:0] ad,
                       input logic st, input logic rv, input logic [3:0] sel, input logic [3:0] sq);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 0;
        drive(d, v, idx, c);
        vec++;
        e.id = vec; e.m = m; e.gnt = g; e.ai = ai; e.ad = ad;
        e.st = st; e.rv = rv; e.sel = sel; e.sq = sq;
        q.push_back(e);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        drive(0, 0, 4'b0000, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        drive(0, 0, 4'b0000, 0);
        do_reset();
        // fill all four slots, fifth dispatch refused
        cyc(1,0,4'b0000,0, 4'b0000,1,4'b0001,4'b0000, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0001,1,4'b0010,4'b0001, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0011,1,4'b0100,4'b0011, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0111,1,4'b1000,4'b0111, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b1111,0,4'b0000,4'b1111, 1,0,4'b0000,4'b0000);
        // free slot 3 while full with dispatch: no bypass
        cyc(1,1,4'b1000,1, 4'b1111,0,4'b0000,4'b0111, 1,0,4'b0000,4'b0000);
        // correct resolve of slot 1 with dispatch into slot 3
        cyc(1,1,4'b0010,1, 4'b0111,1,4'b1000,4'b0101, 0,0,4'b0000,4'b0000);
        cyc(0,0,4'b0000,0, 4'b1101,0,4'b0000,4'b1101, 0,0,4'b0000,4'b0000);
        do_reset();
        // mispredict slot 1 of three
        cyc(1,0,4'b0000,0, 4'b0000,1,4'b0001,4'b0000, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0001,1,4'b0010,4'b0001, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0011,1,4'b0100,4'b0011, 0,0,4'b0000,4'b0000);
        cyc(1,1,4'b0010,0, 4'b0111,0,4'b0000,4'b0111, 1,1,4'b0010,4'b0110);
        cyc(1,0,4'b0000,0, 4'b0001,0,4'b0000,4'b0001, 1,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0001,1,4'b0010,4'b0001, 0,0,4'b0000,4'b0000);
        // ignored resolutions: not live, not one-hot
        cyc(0,1,4'b0100,0, 4'b0011,0,4'b0000,4'b0011, 0,0,4'b0000,4'b0000);
        cyc(0,1,4'b0011,1, 4'b0011,0,4'b0000,4'b0011, 0,0,4'b0000,4'b0000);
        cyc(0,1,4'b0011,0, 4'b0011,0,4'b0000,4'b0011, 0,0,4'b0000,4'b0000);
        // back-to-back mispredicts, second one in RECOVER
        cyc(1,0,4'b0000,0, 4'b0011,1,4'b0100,4'b0011, 0,0,4'b0000,4'b0000);
        cyc(0,1,4'b0100,0, 4'b0111,0,4'b0000,4'b0111, 1,1,4'b0100,4'b0100);
        cyc(1,1,4'b0001,0, 4'b0011,0,4'b0000,4'b0011, 1,1,4'b0001,4'b0011);
        cyc(1,0,4'b0000,0, 4'b0000,0,4'b0000,4'b0000, 1,0,4'b0000,4'b0000);
        cyc(0,0,4'b0000,0, 4'b0000,0,4'b0000,4'b0000, 0,0,4'b0000,4'b0000);
        // reset right after a mispredict
        cyc(1,0,4'b0000,0, 4'b0000,1,4'b0001,4'b0000, 0,0,4'b0000,4'b0000);
        cyc(1,0,4'b0000,0, 4'b0001,1,4'b0010,4'b0001, 0,0,4'b0000,4'b0000);
        cyc(0,1,4'b0010,0, 4'b0011,0,4'b0000,4'b0011, 1,1,4'b0010,4'b0010);
        do_reset();
        cyc(1,0,4'b0000,0, 4'b0000,1,4'b0001,4'b0000, 0,0,4'b0000,4'b0000);
        cyc(0,0,4'b0000,0, 4'b0001,0,4'b0000,4'b0001, 0,0,4'b0000,4'b0000);
        @(posedge clk);
        #1;
        drive(0, 0, 4'b0000, 0);
        repeat (3) @(posedge clk);
        asserts++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end
endmodule
